// File: rtl/geofence_sched.sv
`timescale 1ns/1ps
// Geofence sequencing core: loads an object point plus N_AP anchors, sorts the anchors by angle
// around anchor 1, then tests the object against every polygon edge using a shared cross-product unit.
module geofence_sched #(
  parameter int N_AP = 6,
  parameter int CW   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CW-1:0]        X,
  input  logic [CW-1:0]        Y,
  output logic                 valid,
  output logic                 is_inside,
  output logic                 cp_req,
  output logic signed [CW:0]   cp_ax,
  output logic signed [CW:0]   cp_ay,
  output logic signed [CW:0]   cp_bx,
  output logic signed [CW:0]   cp_by,
  input  logic                 cp_ack,
  input  logic                 cp_neg,
  input  logic                 cp_zero
);

  localparam int NP = N_AP + 1;
  localparam int IW = $clog2(N_AP + 2);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_SORT = 2'd1;
  localparam logic [1:0] S_TEST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          state;
  logic [IW-1:0]       cnt, idx, pass, k;
  logic                first_neg, same_ok, zero_seen;
  logic signed [CW:0]  px [NP];
  logic signed [CW:0]  py [NP];

  // Operand selection: A = P[ia] - P[ic], B = P[ib] - P[ic]
  logic [IW-1:0]       ia, ib, ic, idx_n;
  logic signed [CW:0]  ax_n, ay_n, bx_n, by_n;

  always_comb begin
    idx_n = idx + 1'b1;
    ia    = idx;
    ib    = idx_n;
    ic    = IW'(1);
    if (state == S_TEST) begin
      ia = (k == IW'(N_AP)) ? IW'(1) : k + 1'b1;
      ib = '0;
      ic = k;
    end
    ax_n = px[ia] - px[ic];
    ay_n = py[ia] - py[ic];
    bx_n = px[ib] - px[ic];
    by_n = py[ib] - py[ic];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_LOAD;
      cnt       <= '0;
      idx       <= '0;
      pass      <= '0;
      k         <= '0;
      first_neg <= 1'b0;
      same_ok   <= 1'b0;
      zero_seen <= 1'b0;
      valid     <= 1'b0;
      is_inside <= 1'b0;
      cp_req    <= 1'b0;
      cp_ax     <= '0;
      cp_ay     <= '0;
      cp_bx     <= '0;
      cp_by     <= '0;
      for (int j = 0; j < NP; j++) begin
        px[j] <= '0;
        py[j] <= '0;
      end
    end else begin
      valid <= 1'b0;
      case (state)
        // DONE doubles as the first LOAD cycle of the next object
        S_LOAD, S_DONE: begin
          px[cnt] <= {1'b0, X};
          py[cnt] <= {1'b0, Y};
          if (cnt == IW'(N_AP)) begin
            cnt   <= '0;
            idx   <= IW'(2);
            pass  <= '0;
            state <= S_SORT;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= S_LOAD;
          end
        end
        S_SORT, S_TEST: begin
          if (!cp_req) begin
            cp_req <= 1'b1;
            cp_ax  <= ax_n;
            cp_ay  <= ay_n;
            cp_bx  <= bx_n;
            cp_by  <= by_n;
          end else if (cp_ack) begin
            cp_req <= 1'b0;
            if (state == S_SORT) begin
              if (cp_neg) begin
                px[idx]   <= px[idx_n];
                py[idx]   <= py[idx_n];
                px[idx_n] <= px[idx];
                py[idx_n] <= py[idx];
              end
              if (idx == IW'(N_AP - 1)) begin
                idx <= IW'(2);
                if (pass == IW'(N_AP - 3)) begin
                  k     <= IW'(1);
                  state <= S_TEST;
                end else begin
                  pass <= pass + 1'b1;
                end
              end else begin
                idx <= idx_n;
              end
            end else begin
              if (k == IW'(1)) begin
                first_neg <= cp_neg;
                same_ok   <= 1'b1;
                zero_seen <= cp_zero;
              end else begin
                same_ok   <= same_ok && (cp_neg == first_neg);
                zero_seen <= zero_seen || cp_zero;
              end
              if (k == IW'(N_AP)) begin
                valid     <= 1'b1;
                is_inside <= same_ok && (cp_neg == first_neg) && !zero_seen && !cp_zero;
                state     <= S_DONE;
              end else begin
                k <= k + 1'b1;
              end
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_sched.sv
`timescale 1ns/1ps
// Bench for geofence_sched: directed polygon cases, behavioural cross-product unit with
// variable ack latency and spurious acks, mid-sort reset, and a back-to-back object run.
module tb_geofence_sched;

  localparam int N_AP = 6;
  localparam int CW   = 10;
  localparam int NC   = 9;

  logic clk, reset;
  logic [CW-1:0] X, Y;
  logic valid, is_inside, cp_req, cp_ack, cp_neg, cp_zero;
  logic signed [CW:0] cp_ax, cp_ay, cp_bx, cp_by;

  geofence_sched #(.N_AP(N_AP), .CW(CW)) dut (
    .clk(clk), .reset(reset), .X(X), .Y(Y), .valid(valid), .is_inside(is_inside),
    .cp_req(cp_req), .cp_ax(cp_ax), .cp_ay(cp_ay), .cp_bx(cp_bx), .cp_by(cp_by),
    .cp_ack(cp_ack), .cp_neg(cp_neg), .cp_zero(cp_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;
  int max_lat = 0;
  bit spur_en = 1'b0;
  logic [0:0] exp_q[$];

  // Two orderings of the same hexagon; anchor 1 is the pivot (600,300) in both
  int anc_x [2][N_AP] = '{'{600, 300, 400, 700, 400, 600}, '{600, 400, 600, 300, 700, 400}};
  int anc_y [2][N_AP] = '{'{300, 500, 700, 500, 300, 700}, '{300, 300, 700, 500, 500, 700}};
  int obj_x [NC] = '{500, 900, 500, 400, 600, 650, 350, 700, 300};
  int obj_y [NC] = '{500, 900, 300, 500, 600, 400, 600, 500, 300};
  int obj_s [NC] = '{0,   0,   0,   1,   1,   1,   0,   1,   0};
  bit obj_e [NC] = '{1,   0,   0,   1,   1,   0,   0,   0,   0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // behavioural cross-product unit
  initial begin : cp_model
    bit in_txn;
    int wcnt;
    longint lax, lay, lbx, lby, cr;
    cp_ack = 1'b0; cp_neg = 1'b0; cp_zero = 1'b0;
    in_txn = 1'b0; wcnt = 0;
    lax = 0; lay = 0; lbx = 0; lby = 0;
    forever begin
      @(negedge clk);
      cp_ack = 1'b0;
      if (!cp_req) begin
        in_txn = 1'b0;
        if (spur_en) begin
          cp_neg  = 1'($urandom_range(1, 0));
          cp_zero = 1'($urandom_range(1, 0));
          cp_ack  = 1'($urandom_range(1, 0));
        end
      end else begin
        if (!in_txn) begin
          in_txn = 1'b1;
          lax = cp_ax; lay = cp_ay; lbx = cp_bx; lby = cp_by;
          wcnt = $urandom_range(max_lat, 0);
        end else begin
          check("operand_stable", {cp_ax, cp_ay, cp_bx, cp_by},
                {11'(lax), 11'(lay), 11'(lbx), 11'(lby)});
        end
        if (wcnt == 0) begin
          cr = lax * lby - lbx * lay;
          cp_ack  = 1'b1;
          cp_neg  = (cr < 0);
          cp_zero = (cr == 0);
          ack_cnt++;
          in_txn = 1'b0;
        end else begin
          wcnt--;
        end
      end
    end
  end

  // monitor: pops the expected verdict whenever a result strobe appears
  initial begin : monitor
    logic prev_valid;
    logic [0:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (valid) begin
        check("valid_width", prev_valid, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("is_inside", is_inside, e);
        end
        check("ack_count", ack_cnt, 22);
        ack_cnt = 0;
      end
      prev_valid = valid;
    end
  end

  task automatic drive_points(input int c);
    int s;
    s = obj_s[c];
    X = CW'(obj_x[c]); Y = CW'(obj_y[c]);
    @(negedge clk);
    for (int p = 0; p < N_AP; p++) begin
      X = CW'(anc_x[s][p]); Y = CW'(anc_y[s][p]);
      @(negedge clk);
    end
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!valid) check("valid_timeout", 0, 1);
  endtask

  // starts at a negedge, returns at the negedge where valid is seen
  task automatic run_object(input int c);
    exp_q.push_back(obj_e[c]);
    drive_points(c);
    wait_valid();
  endtask

  initial begin : main
    int t;
    reset = 1'b0; X = '0; Y = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_inside", is_inside, 0);
    check("rst_req", cp_req, 0);
    check("rst_ops", {cp_ax, cp_ay, cp_bx, cp_by}, 0);

    reset = 1'b1;
    max_lat = 0;
    for (int c = 0; c < NC; c++) run_object(c);

    max_lat = 7;
    spur_en = 1'b1;
    for (int c = 0; c < NC; c++) run_object(c);

    // leave is_inside=1, then abort the next object mid-sort
    run_object(0);
    drive_points(1);
    t = 0;
    while (ack_cnt < 5 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reach_sort", ack_cnt >= 5, 1);
    reset = 1'b0;
    #1;
    check("abort_valid", valid, 0);
    check("abort_inside", is_inside, 0);
    check("abort_req", cp_req, 0);
    repeat (3) @(negedge clk);
    ack_cnt = 0;
    reset = 1'b1;
    run_object(3);

    for (int n = 0; n < 50; n++) run_object(n % NC);

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
